// File: rtl/controlador_banco_de_registradores.sv
// rtl/controlador_banco_de_registradores.sv - request sequencer for the 32x32 register bank
// Accepts read-pair/write requests, drives the bank pins and returns read data with a held handshake.
module controlador_banco_de_registradores #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 5,
    parameter bit ZERO_REG_PROTECT = 1'b1
) (
    input  logic                  Clock_in,
    input  logic                  Signal_reset,
    input  logic                  Req_valid,
    output logic                  Req_ready,
    input  logic                  Req_write,
    input  logic [ADDR_WIDTH-1:0] Req_addr_a,
    input  logic [ADDR_WIDTH-1:0] Req_addr_b,
    input  logic [DATA_WIDTH-1:0] Req_data,
    input  logic                  Clear_request,
    output logic                  Resp_valid,
    input  logic                  Resp_ready,
    output logic [DATA_WIDTH-1:0] Resp_data_1,
    output logic [DATA_WIDTH-1:0] Resp_data_2,
    output logic                  Write_ack,
    output logic                  Clear_done,
    output logic                  Busy,
    output logic [ADDR_WIDTH-1:0] Read_1,
    output logic [ADDR_WIDTH-1:0] Read_2,
    output logic [ADDR_WIDTH-1:0] Address_to_write,
    output logic [DATA_WIDTH-1:0] Data_to_write,
    output logic                  Signal_write,
    output logic                  Bank_reset,
    input  logic [DATA_WIDTH-1:0] Bank_out_1,
    input  logic [DATA_WIDTH-1:0] Bank_out_2
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t state;
    logic   clear_pending;

    assign Req_ready = (state == S_IDLE) && !Clear_request && !clear_pending && !Signal_reset;
    assign Busy      = (state != S_IDLE);

    // Bank pins are registered and loaded on the edge that enters the state that uses them.
    always_ff @(posedge Clock_in or posedge Signal_reset) begin
        if (Signal_reset) begin
            state            <= S_CLEAR;
            Bank_reset       <= 1'b1;
            clear_pending    <= 1'b0;
            Resp_valid       <= 1'b0;
            Resp_data_1      <= '0;
            Resp_data_2      <= '0;
            Read_1           <= '0;
            Read_2           <= '0;
            Address_to_write <= '0;
            Data_to_write    <= '0;
            Signal_write     <= 1'b0;
            Write_ack        <= 1'b0;
            Clear_done       <= 1'b0;
        end else begin
            Signal_write <= 1'b0;
            Write_ack    <= 1'b0;
            Clear_done   <= 1'b0;
            Bank_reset   <= 1'b0;
            if (Clear_request && state != S_IDLE) begin
                clear_pending <= 1'b1;
            end
            case (state)
                S_CLEAR: begin
                    state      <= S_IDLE;
                    Clear_done <= 1'b1;
                end
                S_IDLE: begin
                    if (Clear_request || clear_pending) begin
                        state         <= S_CLEAR;
                        Bank_reset    <= 1'b1;
                        clear_pending <= 1'b0;
                    end else if (Req_valid) begin
                        if (Req_write) begin
                            state            <= S_WRITE;
                            Address_to_write <= Req_addr_a;
                            Data_to_write    <= Req_data;
                            Write_ack        <= 1'b1;
                            Signal_write     <= !(ZERO_REG_PROTECT && Req_addr_a == '0);
                        end else begin
                            state  <= S_READ;
                            Read_1 <= Req_addr_a;
                            Read_2 <= Req_addr_b;
                        end
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_READ:  state <= S_CAPTURE;
                S_CAPTURE: begin
                    Resp_data_1 <= Bank_out_1;
                    Resp_data_2 <= Bank_out_2;
                    Resp_valid  <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (Resp_ready) begin
                        Resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_banco_de_registradores.sv
// tb/tb_controlador_banco_de_registradores.sv - self-checking bench with bank model and reference register file
module tb_controlador_banco_de_registradores;

    logic        Clock_in = 1'b0;
    logic        Signal_reset;
    logic        Req_valid, Req_ready, Req_write;
    logic [4:0]  Req_addr_a, Req_addr_b;
    logic [31:0] Req_data;
    logic        Clear_request, Resp_valid, Resp_ready;
    logic [31:0] Resp_data_1, Resp_data_2;
    logic        Write_ack, Clear_done, Busy;
    logic [4:0]  Read_1, Read_2, Address_to_write;
    logic [31:0] Data_to_write;
    logic        Signal_write, Bank_reset;
    logic [31:0] Bank_out_1, Bank_out_2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] bank_mem [32];
    logic [31:0] ref_mem  [32];

    always #5 Clock_in = ~Clock_in;

    controlador_banco_de_registradores #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_PROTECT(1'b1)
    ) dut (
        .Clock_in(Clock_in), .Signal_reset(Signal_reset),
        .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_write(Req_write),
        .Req_addr_a(Req_addr_a), .Req_addr_b(Req_addr_b), .Req_data(Req_data),
        .Clear_request(Clear_request), .Resp_valid(Resp_valid), .Resp_ready(Resp_ready),
        .Resp_data_1(Resp_data_1), .Resp_data_2(Resp_data_2),
        .Write_ack(Write_ack), .Clear_done(Clear_done), .Busy(Busy),
        .Read_1(Read_1), .Read_2(Read_2), .Address_to_write(Address_to_write),
        .Data_to_write(Data_to_write), .Signal_write(Signal_write), .Bank_reset(Bank_reset),
        .Bank_out_1(Bank_out_1), .Bank_out_2(Bank_out_2)
    );

    // Register bank: sync clear, writes win over reads, read data registered one edge late.
    always @(posedge Clock_in) begin
        if (Bank_reset) begin
            for (int i = 0; i < 32; i++) bank_mem[i] <= 32'h0;
        end else if (Signal_write) begin
            bank_mem[Address_to_write] <= Data_to_write;
        end else begin
            Bank_out_1 <= bank_mem[Read_1];
            Bank_out_2 <= bank_mem[Read_2];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock_in);
        #1;
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!Req_ready && n < 20) begin
            step();
            n++;
        end
        if (!Req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: Req_ready=0 after 20 cycles, expected 1");
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wait_ready();
        Req_valid = 1'b1; Req_write = 1'b1; Req_addr_a = a; Req_data = d;
        Req_addr_b = 5'($urandom_range(0, 31));
        step();
        Req_valid = 1'b0;
        check("wr_signal_write", 32'(Signal_write), 32'(a != 5'd0));
        check("wr_ack", 32'(Write_ack), 32'd1);
        check("wr_busy", 32'(Busy), 32'd1);
        if (a != 5'd0) begin
            check("wr_addr", 32'(Address_to_write), 32'(a));
            check("wr_data", Data_to_write, d);
            ref_mem[a] = d;
        end
        step();
        check("wr_ack_off", 32'(Write_ack), 32'd0);
        check("wr_signal_write_off", 32'(Signal_write), 32'd0);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           output logic [31:0] r1, output logic [31:0] r2);
        wait_ready();
        Req_valid = 1'b1; Req_write = 1'b0; Req_addr_a = a; Req_addr_b = b;
        Req_data = $urandom;
        step();
        Req_valid = 1'b0;
        check("rd_read1", 32'(Read_1), 32'(a));
        check("rd_read2", 32'(Read_2), 32'(b));
        check("rd_no_write", 32'(Signal_write), 32'd0);
        check("rd_valid_e1", 32'(Resp_valid), 32'd0);
        step();
        check("rd_valid_e2", 32'(Resp_valid), 32'd0);
        step();
        check("rd_resp_valid", 32'(Resp_valid), 32'd1);
        check("rd_req_ready_low", 32'(Req_ready), 32'd0);
        r1 = Resp_data_1;
        r2 = Resp_data_2;
        Resp_ready = 1'b1;
        step();
        Resp_ready = 1'b0;
        check("rd_resp_drop", 32'(Resp_valid), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] d;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0] r1, r2;
        int op;
        logic [4:0] ra, rb;

        tbl[0] = '{1'b0, 5'd3,  5'd7,  32'h0,        32'h0,        32'h0};
        tbl[1] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        tbl[2] = '{1'b0, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b1, 5'd0,  5'd0,  32'h12345678, 32'h0,        32'h0};
        tbl[4] = '{1'b0, 5'd0,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF};
        tbl[5] = '{1'b1, 5'd31, 5'd0,  32'hA5A5A5A5, 32'h0,        32'h0};
        tbl[6] = '{1'b1, 5'd5,  5'd0,  32'h00000001, 32'h0,        32'h0};
        tbl[7] = '{1'b0, 5'd5,  5'd31, 32'h0,        32'h00000001, 32'hA5A5A5A5};

        Signal_reset = 1'b1; Req_valid = 1'b0; Req_write = 1'b0;
        Req_addr_a = '0; Req_addr_b = '0; Req_data = '0;
        Clear_request = 1'b0; Resp_ready = 1'b0;
        ref_clear();

        repeat (3) step();
        check("rst_bank_reset", 32'(Bank_reset), 32'd1);
        check("rst_req_ready", 32'(Req_ready), 32'd0);
        check("rst_busy", 32'(Busy), 32'd1);
        check("rst_resp_valid", 32'(Resp_valid), 32'd0);
        check("rst_write_ack", 32'(Write_ack), 32'd0);
        check("rst_clear_done", 32'(Clear_done), 32'd0);
        check("rst_signal_write", 32'(Signal_write), 32'd0);
        check("rst_read1", 32'(Read_1), 32'd0);
        check("rst_data_to_write", Data_to_write, 32'd0);
        Signal_reset = 1'b0;
        #1;
        check("rel_bank_reset_held", 32'(Bank_reset), 32'd1);
        step();
        check("rel_bank_reset_off", 32'(Bank_reset), 32'd0);
        check("rel_clear_done", 32'(Clear_done), 32'd1);
        check("rel_req_ready", 32'(Req_ready), 32'd1);
        check("rel_busy", 32'(Busy), 32'd0);
        step();
        check("rel_clear_done_off", 32'(Clear_done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].a, tbl[i].d);
            end else begin
                do_read(tbl[i].a, tbl[i].b, r1, r2);
                check($sformatf("tbl%0d_data1", i), r1, tbl[i].e1);
                check($sformatf("tbl%0d_data2", i), r2, tbl[i].e2);
            end
        end

        // Response stall with a clear request arriving mid-response.
        do_write(5'd5, 32'hCAFEF00D);
        wait_ready();
        Req_valid = 1'b1; Req_write = 1'b0; Req_addr_a = 5'd5; Req_addr_b = 5'd0;
        step();
        Req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(Resp_valid), 32'd1);
            check("stall_data1", Resp_data_1, 32'hCAFEF00D);
            check("stall_data2", Resp_data_2, 32'h0);
            check("stall_req_ready", 32'(Req_ready), 32'd0);
            if (i == 1) Clear_request = 1'b1;
            step();
            Clear_request = 1'b0;
        end
        Resp_ready = 1'b1;
        step();
        Resp_ready = 1'b0;
        check("stall_valid_drop", 32'(Resp_valid), 32'd0);
        check("stall_pending_blocks", 32'(Req_ready), 32'd0);
        step();
        check("stall_clear_runs", 32'(Bank_reset), 32'd1);
        step();
        check("stall_clear_done", 32'(Clear_done), 32'd1);
        ref_clear();
        do_read(5'd5, 5'd31, r1, r2);
        check("post_clear_r5", r1, 32'h0);
        check("post_clear_r31", r2, 32'h0);

        // Clear and a request presented together: clear first.
        wait_ready();
        Clear_request = 1'b1;
        Req_valid = 1'b1; Req_write = 1'b1; Req_addr_a = 5'd9; Req_data = 32'h11112222;
        #1;
        check("both_req_ready", 32'(Req_ready), 32'd0);
        step();
        Clear_request = 1'b0;
        check("both_clear_first", 32'(Bank_reset), 32'd1);
        check("both_no_ack", 32'(Write_ack), 32'd0);
        step();
        check("both_clear_done", 32'(Clear_done), 32'd1);
        check("both_ready_after", 32'(Req_ready), 32'd1);
        step();
        Req_valid = 1'b0;
        check("both_write_ack", 32'(Write_ack), 32'd1);
        check("both_write_addr", 32'(Address_to_write), 32'd9);
        ref_clear();
        ref_mem[9] = 32'h11112222;
        step();
        do_read(5'd9, 5'd5, r1, r2);
        check("both_r9", r1, 32'h11112222);
        check("both_r5", r2, 32'h0);

        // Reset arriving during CAPTURE.
        wait_ready();
        Req_valid = 1'b1; Req_write = 1'b0; Req_addr_a = 5'd9; Req_addr_b = 5'd9;
        step();
        Req_valid = 1'b0;
        step();
        Signal_reset = 1'b1;
        #1;
        check("arst_bank_reset", 32'(Bank_reset), 32'd1);
        check("arst_busy", 32'(Busy), 32'd1);
        check("arst_read1", 32'(Read_1), 32'd0);
        check("arst_addr_wr", 32'(Address_to_write), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst_no_resp", 32'(Resp_valid), 32'd0);
            check("arst_data1", Resp_data_1, 32'h0);
        end
        Signal_reset = 1'b0;
        step();
        check("arst_clear_done", 32'(Clear_done), 32'd1);
        ref_clear();

        // Randomized traffic against the reference register file.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            if (op < 4) begin
                do_write(ra, $urandom);
            end else if (op < 9) begin
                do_read(ra, rb, r1, r2);
                check("rand_data1", r1, ref_mem[ra]);
                check("rand_data2", r2, ref_mem[rb]);
            end else begin
                wait_ready();
                Clear_request = 1'b1;
                step();
                Clear_request = 1'b0;
                check("rand_clear", 32'(Bank_reset), 32'd1);
                step();
                check("rand_clear_done", 32'(Clear_done), 32'd1);
                ref_clear();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
